// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR burst controller and its LFSR core:
//   - lfsr_state_e : controller FSM state encoding (IDLE, LOAD, RUN, DONE)
//   - TAP_*        : zero-based bit indices of the Fibonacci XNOR taps
//                    (polynomial taps 16, 15, 13, 4 -> bits 15, 14, 12, 3)
//   - LOCKUP_FIX   : helper that replaces the XNOR lock-up seed (all ones)
// ---------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } lfsr_state_e;

    localparam int TAP_A = 15;
    localparam int TAP_B = 14;
    localparam int TAP_C = 12;
    localparam int TAP_D = 3;

    // An XNOR LFSR stuck at all ones never leaves it, so that seed is
    // swapped for all zeros, which is a legal point on the sequence.
    function automatic logic [15:0] lockup_fix(input logic [15:0] seed);
        return (&seed) ? 16'h0000 : seed;
    endfunction

endpackage

// File: rtl/lfsr16_core.sv
// ---------------------------------------------------------------------------
// lfsr16_core
// Fibonacci XNOR LFSR register. Shifts left by one bit per enabled cycle,
// with the XNOR of the tap bits entering at bit 0. Load has priority over
// enable. Holds its value when neither is asserted.
// Ports:
//   i_Clk    : clock, rising edge
//   i_Rst    : synchronous active-high reset, clears the state to zero
//   i_Load   : load i_Seed into the state
//   i_Enable : advance the sequence by one step
//   i_Seed   : value to load
//   o_State  : current LFSR state
// ---------------------------------------------------------------------------
module lfsr16_core
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS = 16
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Load,
    input  logic                i_Enable,
    input  logic [NUM_BITS-1:0] i_Seed,
    output logic [NUM_BITS-1:0] o_State
);

    logic [NUM_BITS-1:0] r_State;
    logic                w_Feedback;

    assign w_Feedback = ~(r_State[TAP_A] ^ r_State[TAP_B] ^ r_State[TAP_C] ^ r_State[TAP_D]);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State <= '0;
        end else if (i_Load) begin
            r_State <= i_Seed;
        end else if (i_Enable) begin
            r_State <= {r_State[NUM_BITS-2:0], w_Feedback};
        end
    end

    assign o_State = r_State;

endmodule

// File: rtl/lfsr_burst_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_burst_ctrl
// Accepts a burst request (seed + word count) and streams that many LFSR
// words over a valid/ready interface, then pulses o_Done. A burst may be
// cut short by i_Abort, which is reported through o_Aborted with o_Done.
// Ports:
//   i_Clk, i_Rst              : clock and synchronous active-high reset
//   i_Start_Valid/o_Start_Ready : request handshake
//   i_Seed, i_Count           : burst seed and length, sampled on handshake
//   i_Abort                   : ends an active burst (LOAD or RUN)
//   o_Data/o_Valid/i_Ready    : output word stream
//   o_Busy                    : controller not in IDLE
//   o_Done, o_Aborted         : end-of-burst pulse and its abort qualifier
// ---------------------------------------------------------------------------
module lfsr_burst_ctrl
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS = 16,
    parameter int CNT_BITS = 16
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Start_Valid,
    output logic                o_Start_Ready,
    input  logic [NUM_BITS-1:0] i_Seed,
    input  logic [CNT_BITS-1:0] i_Count,
    input  logic                i_Abort,
    output logic [NUM_BITS-1:0] o_Data,
    output logic                o_Valid,
    input  logic                i_Ready,
    output logic                o_Busy,
    output logic                o_Done,
    output logic                o_Aborted
);

    lfsr_state_e         r_State;
    logic [NUM_BITS-1:0] r_Seed;
    logic [CNT_BITS-1:0] r_Remaining;
    logic                r_Aborted;

    logic                w_Beat;
    logic                w_Load;
    logic [NUM_BITS-1:0] w_SeedFixed;
    logic [NUM_BITS-1:0] w_CoreState;

    assign w_Beat      = (r_State == ST_RUN) && i_Ready;
    assign w_Load      = (r_State == ST_LOAD);
    assign w_SeedFixed = lockup_fix(r_Seed);

    // The core is loaded on every LOAD cycle, even for zero-length or
    // aborted bursts; nothing is presented then, so the load is harmless.
    lfsr16_core #(
        .NUM_BITS (NUM_BITS)
    ) u_core (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Load   (w_Load),
        .i_Enable (w_Beat),
        .i_Seed   (w_SeedFixed),
        .o_State  (w_CoreState)
    );

    // Burst sequencing. Reset wins over abort and handshake. In RUN a beat
    // that coincides with an abort still decrements the count (the word was
    // delivered); the abort then forces DONE regardless of what remains.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State     <= ST_IDLE;
            r_Seed      <= '0;
            r_Remaining <= '0;
            r_Aborted   <= 1'b0;
        end else begin
            unique case (r_State)
                ST_IDLE: begin
                    if (i_Start_Valid) begin
                        r_Seed      <= i_Seed;
                        r_Remaining <= i_Count;
                        r_Aborted   <= 1'b0;
                        r_State     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (i_Abort) begin
                        r_Aborted <= 1'b1;
                        r_State   <= ST_DONE;
                    end else if (r_Remaining == '0) begin
                        r_State <= ST_DONE;
                    end else begin
                        r_State <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_Beat) begin
                        r_Remaining <= r_Remaining - CNT_BITS'(1);
                    end
                    if (i_Abort) begin
                        r_Aborted <= 1'b1;
                        r_State   <= ST_DONE;
                    end else if (w_Beat && (r_Remaining == CNT_BITS'(1))) begin
                        r_State <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_State <= ST_IDLE;
                end
                default: begin
                    r_State <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Start_Ready = (r_State == ST_IDLE);
    assign o_Valid       = (r_State == ST_RUN);
    assign o_Data        = w_CoreState;
    assign o_Busy        = (r_State != ST_IDLE);
    assign o_Done        = (r_State == ST_DONE);
    assign o_Aborted     = (r_State == ST_DONE) && r_Aborted;

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lfsr_burst_ctrl
// Self-checking bench for lfsr_burst_ctrl. Expected words are queued when a
// burst is requested and popped by a monitor on every observed beat.
// ---------------------------------------------------------------------------
module tb_lfsr_burst_ctrl;

    logic        clk;
    logic        rst;
    logic        startValid;
    logic        startReady;
    logic [15:0] seed;
    logic [15:0] count;
    logic        abort;
    logic [15:0] data;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        done;
    logic        aborted;

    int          checks;
    int          errors;
    int          beatCount;
    int          doneCount;
    logic        lastAborted;
    logic [15:0] expQ[$];

    lfsr_burst_ctrl #(
        .NUM_BITS (16),
        .CNT_BITS (16)
    ) dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Start_Valid (startValid),
        .o_Start_Ready (startReady),
        .i_Seed        (seed),
        .i_Count       (count),
        .i_Abort       (abort),
        .o_Data        (data),
        .o_Valid       (valid),
        .i_Ready       (ready),
        .o_Busy        (busy),
        .o_Done        (done),
        .o_Aborted     (aborted)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every comparison funnels through here so the counters stay honest
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference next-state: shift left, XNOR of bits 15, 14, 12, 3 into bit 0
    function automatic logic [15:0] modelStep(input logic [15:0] s);
        return {s[14:0], ~(s[15] ^ s[14] ^ s[12] ^ s[3])};
    endfunction

    // Scoreboard monitor: each beat pops one expected word
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            beatCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_beat", 32'd1, 32'd0);
            end else begin
                checkOutput("beat_data", {16'h0, data}, {16'h0, expQ.pop_front()});
            end
        end
        if (!rst && done) begin
            doneCount++;
            lastAborted = aborted;
        end
    end

    // Perform one request handshake; returns 1 ns after the accepting edge
    task automatic doStart(input logic [15:0] s, input logic [15:0] c);
        @(posedge clk);
        #1;
        startValid = 1'b1;
        seed       = s;
        count      = c;
        @(negedge clk);
        checkOutput("start_ready", {31'h0, startReady}, 32'd1);
        @(posedge clk);
        #1;
        startValid = 1'b0;
    endtask

    // Queue the model's words for a burst, then request it
    task automatic applyStimulus(input logic [15:0] s, input logic [15:0] c, input bit pushModel);
        logic [15:0] w;
        w = (s == 16'hFFFF) ? 16'h0000 : s;
        if (pushModel) begin
            for (int i = 0; i < c; i++) begin
                expQ.push_back(w);
                w = modelStep(w);
            end
        end
        doStart(s, c);
    endtask

    // Bounded wait for the next o_Done pulse
    task automatic waitDone(input int maxCycles);
        int startDone;
        bit seen;
        startDone = doneCount;
        seen      = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(posedge clk);
            if (doneCount != startDone) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        beatCount   = 0;
        doneCount   = 0;
        lastAborted = 1'b0;
        rst         = 1'b1;
        startValid  = 1'b0;
        seed        = '0;
        count       = '0;
        abort       = 1'b0;
        ready       = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", {31'h0, startReady}, 32'd1);
        checkOutput("rst_valid", {31'h0, valid}, 32'd0);
        checkOutput("rst_busy", {31'h0, busy}, 32'd0);
        checkOutput("rst_done", {31'h0, done}, 32'd0);
        checkOutput("rst_data", {16'h0, data}, 32'd0);
        rst = 1'b0;

        // Abort while idle is ignored
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checkOutput("idle_abort_busy", {31'h0, busy}, 32'd0);
        checkOutput("idle_abort_done", {31'h0, done}, 32'd0);

        // Seed 0, count 4, ready high: fixed expected words and latency
        $display("[TB] burst seed 0000 count 4");
        beatCount = 0;
        expQ.push_back(16'h0000);
        expQ.push_back(16'h0001);
        expQ.push_back(16'h0003);
        expQ.push_back(16'h0007);
        applyStimulus(16'h0000, 16'd4, 1'b0);
        @(negedge clk);
        checkOutput("lat_load_valid", {31'h0, valid}, 32'd0);
        @(negedge clk);
        checkOutput("lat_run_valid", {31'h0, valid}, 32'd1);
        waitDone(20);
        checkOutput("b1_beats", beatCount, 32'd4);
        checkOutput("b1_aborted", {31'h0, lastAborted}, 32'd0);
        checkOutput("b1_queue", expQ.size(), 32'd0);
        @(negedge clk);
        checkOutput("b1_done_pulse", {31'h0, done}, 32'd0);
        checkOutput("b1_ready_back", {31'h0, startReady}, 32'd1);

        // Same burst with back-pressure after the second word
        $display("[TB] burst with back-pressure");
        beatCount = 0;
        expQ.push_back(16'h0000);
        expQ.push_back(16'h0001);
        expQ.push_back(16'h0003);
        expQ.push_back(16'h0007);
        applyStimulus(16'h0000, 16'd4, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("hold_data", {16'h0, data}, 32'h0001);
            checkOutput("hold_valid", {31'h0, valid}, 32'd1);
        end
        @(posedge clk);
        #1 ready = 1'b1;
        waitDone(20);
        checkOutput("b2_beats", beatCount, 32'd4);
        checkOutput("b2_queue", expQ.size(), 32'd0);

        // Zero-length burst
        $display("[TB] zero-length burst");
        beatCount = 0;
        applyStimulus(16'h1234, 16'd0, 1'b1);
        @(negedge clk);
        checkOutput("z_done_early", {31'h0, done}, 32'd0);
        @(negedge clk);
        checkOutput("z_done", {31'h0, done}, 32'd1);
        checkOutput("z_aborted", {31'h0, aborted}, 32'd0);
        @(negedge clk);
        checkOutput("z_ready_back", {31'h0, startReady}, 32'd1);
        checkOutput("z_beats", beatCount, 32'd0);

        // Lock-up seed substitution
        $display("[TB] seed FFFF count 2");
        beatCount = 0;
        expQ.push_back(16'h0000);
        expQ.push_back(16'h0001);
        applyStimulus(16'hFFFF, 16'd2, 1'b0);
        waitDone(20);
        checkOutput("ff_beats", beatCount, 32'd2);
        checkOutput("ff_queue", expQ.size(), 32'd0);

        // Abort after two beats of a 10-word burst
        $display("[TB] abort mid-burst");
        beatCount = 0;
        applyStimulus(16'h0BAD, 16'd10, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        ready = 1'b0;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        checkOutput("ab_done", {31'h0, done}, 32'd1);
        checkOutput("ab_aborted", {31'h0, aborted}, 32'd1);
        checkOutput("ab_valid", {31'h0, valid}, 32'd0);
        @(negedge clk);
        checkOutput("ab_valid_after", {31'h0, valid}, 32'd0);
        checkOutput("ab_beats", beatCount, 32'd2);
        expQ.delete();

        // Long burst with random back-pressure against the model
        $display("[TB] random back-pressure burst");
        beatCount = 0;
        applyStimulus(16'hACE1, 16'd20, 1'b1);
        begin
            int startDone;
            startDone = doneCount;
            for (int i = 0; i < 300; i++) begin
                @(posedge clk);
                if (doneCount != startDone) break;
                #1 ready = 1'($urandom_range(0, 1));
            end
            if (doneCount == startDone) checkOutput("rnd_timeout", 32'd0, 32'd1);
        end
        #1 ready = 1'b1;
        checkOutput("rnd_beats", beatCount, 32'd20);
        checkOutput("rnd_queue", expQ.size(), 32'd0);
        checkOutput("rnd_aborted", {31'h0, lastAborted}, 32'd0);

        // Reset mid-burst with a request held through reset
        $display("[TB] reset mid-burst");
        applyStimulus(16'h00FF, 16'd10, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst        = 1'b1;
        startValid = 1'b1;
        seed       = 16'h1234;
        count      = 16'd3;
        @(posedge clk);
        expQ.delete();
        beatCount = 0;
        @(negedge clk);
        checkOutput("mr_valid", {31'h0, valid}, 32'd0);
        checkOutput("mr_busy", {31'h0, busy}, 32'd0);
        checkOutput("mr_done", {31'h0, done}, 32'd0);
        checkOutput("mr_aborted", {31'h0, aborted}, 32'd0);
        checkOutput("mr_data", {16'h0, data}, 32'd0);
        checkOutput("mr_ready", {31'h0, startReady}, 32'd1);
        begin
            logic [15:0] w;
            w = 16'h1234;
            for (int i = 0; i < 3; i++) begin
                expQ.push_back(w);
                w = modelStep(w);
            end
        end
        rst = 1'b0;
        @(posedge clk);
        #1 startValid = 1'b0;
        @(negedge clk);
        checkOutput("mr_accepted", {31'h0, busy}, 32'd1);
        waitDone(20);
        checkOutput("mr_beats", beatCount, 32'd3);
        checkOutput("mr_queue", expQ.size(), 32'd0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_burst_ctrl.md
LFSR_BURST_CTRL -- requirements
Module: lfsr_burst_ctrl

Interface
REQ-001 SHALL have parameter NUM_BITS, default 16, LFSR and data width.
REQ-002 SHALL have parameter CNT_BITS, default 16, width of the burst-length field.
REQ-003 SHALL have port i_Clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port i_Rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_Start_Valid  input  1  burst request valid.
REQ-006 SHALL have port o_Start_Ready  output  1  controller can accept a request.
REQ-007 SHALL have port i_Seed  input  NUM_BITS  seed for the burst, sampled on request handshake.
REQ-008 SHALL have port i_Count  input  CNT_BITS  number of words to emit, sampled on request handshake.
REQ-009 SHALL have port i_Abort  input  1  terminates the active burst.
REQ-010 SHALL have port o_Data  output  NUM_BITS  current LFSR word.
REQ-011 SHALL have port o_Valid  output  1  o_Data valid.
REQ-012 SHALL have port i_Ready  input  1  downstream accepts o_Data.
REQ-013 SHALL have port o_Busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port o_Done  output  1  one-cycle pulse at burst end (normal, abort or zero-length).
REQ-015 SHALL have port o_Aborted  output  1  qualifies o_Done: burst ended by i_Abort.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-017 SHALL assert o_Start_Ready only in IDLE; a request is accepted when i_Start_Valid and o_Start_Ready are both high.
REQ-018 SHALL, on acceptance, register i_Seed and i_Count and go to LOAD.
REQ-019 SHALL, in LOAD, load the core with the seed and go to RUN; if the registered count is 0, go to DONE instead and emit no words.
REQ-020 SHALL substitute all-ones (the XNOR lock-up value) with all-zeros when loading the seed.
REQ-021 SHALL assert o_Valid only in RUN, with o_Data equal to the core state; the first word equals the loaded seed.
REQ-022 SHALL advance the core by exactly one step per beat (o_Valid and i_Ready), never otherwise; o_Data is held stable while i_Ready is low.
REQ-023 SHALL use the Fibonacci XNOR form: shift left, bit0 gets the XNOR of bits 15, 14, 12 and 3 (taps 16, 15, 13, 4), giving period 65535.
REQ-024 SHALL decrement a remaining-count register on each beat; the beat with remaining equal to 1 moves the FSM to DONE.
REQ-025 SHALL, in DONE, pulse o_Done for one cycle and return to IDLE; o_Start_Ready rises in the following cycle.
REQ-026 SHALL treat i_Abort in LOAD or RUN as ending the burst: go to DONE next cycle with o_Aborted high alongside o_Done; a beat coinciding with the abort still counts as delivered.
REQ-027 SHALL ignore i_Abort in IDLE and in DONE.
REQ-028 SHALL give a latency of 2 cycles from request handshake to first o_Valid.

Reset
REQ-029 SHALL, on i_Rst (including mid-burst), enter IDLE; o_Valid, o_Busy, o_Done and o_Aborted go to 0, o_Data to 0, o_Start_Ready to 1, and the count registers clear.
REQ-030 SHALL give i_Rst priority over i_Abort and over any handshake in the same cycle.

Structure
REQ-031 SHALL place the FSM state enum and the tap constants in shared package lfsr_pkg.
REQ-032 SHALL instantiate one sub-module, lfsr16_core (load, enable, seed in, state out), and keep all sequencing in lfsr_burst_ctrl.

Verification
REQ-033 SHALL cover: seed 16'h0000, count 4, i_Ready held high -> o_Data 0000, 0001, 0003, 0007 on consecutive cycles, then o_Done for one cycle and o_Aborted 0.
REQ-034 SHALL cover: the same burst with i_Ready low for 3 cycles after the second word -> 0001 held stable, the sequence unchanged, and exactly 4 beats.
REQ-035 SHALL cover: count 0 -> no o_Valid, o_Done 2 cycles after the handshake, and o_Start_Ready back high the cycle after.
REQ-036 SHALL cover: seed 16'hFFFF, count 2 -> words 0000, 0001.
REQ-037 SHALL cover: i_Abort after 2 beats of a 10-word burst -> o_Done and o_Aborted together, and no further o_Valid.
REQ-038 SHALL cover: i_Rst mid-burst, then i_Start_Valid held high -> outputs at reset values, and a new burst accepted on the first cycle after reset.
